if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries, legal range 2..4.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port imem_req_valid  output  1  fetch request.
REQ-005 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-006 SHALL have port imem_req_addr  output  32  fetch address, word-aligned.
REQ-007 SHALL have port imem_rsp_valid  input  1  in-order response data valid.
REQ-008 SHALL have port imem_rsp_data  input  32  instruction word.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-010 SHALL have port redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-011 SHALL have port id_valid  output  1  instruction available to decode.
REQ-012 SHALL have port id_ready  input  1  decode accepts this cycle.
REQ-013 SHALL have ports id_instr  output  32 and id_pc  output  32, meaning the buffered instruction and its address.
REQ-014 SHALL have ports id_opcode  output  7, id_funct3  output  3 and id_funct7_5  output  1, sliced from id_instr [6:0], [14:12] and [30], for the decode control unit.

Function
REQ-015 SHALL keep fetch PC; a request is accepted when imem_req_valid && imem_req_ready, and PC then advances by 4, wrapping modulo 2^32.
REQ-016 SHALL drive imem_req_valid = (credit > 0) && !redirect_valid && state==FETCH, where credit = BUF_DEPTH - occupancy - outstanding; imem_req_valid need not stay stable while it is unaccepted.
REQ-017 SHALL drive imem_req_addr = PC combinationally.
REQ-018 SHALL record each accepted request's PC in an address FIFO and pair it, in order, with the matching response.
REQ-019 SHALL write each non-dropped response into the instruction buffer at the clock edge; id_valid asserts the next cycle, giving 1-cycle response-to-decode latency.
REQ-020 SHALL pop the buffer head on id_valid && id_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 SHALL never overflow the buffer, because credit accounting reserves a slot per outstanding request.
REQ-022 SHALL implement FSM states FETCH and FLUSH.
REQ-023 SHALL, on redirect_valid in any state: set PC to {redirect_pc[31:2],2'b00}, clear the buffer and address FIFO, and load drop_cnt with outstanding minus any response arriving in that same cycle.
REQ-024 SHALL go to FLUSH if that drop_cnt is non-zero and to FETCH otherwise.
REQ-025 SHALL, in FLUSH, discard each response, decrementing drop_cnt, issue no requests, and return to FETCH when drop_cnt reaches 0.
REQ-026 SHALL, when redirect and id handshake coincide, let the redirect win; the popped instruction is consumed and everything else is cleared.
REQ-027 SHALL ensure a response arriving in the redirect cycle is dropped and never reaches id_*.
REQ-028 SHALL size outstanding and drop_cnt as $clog2(BUF_DEPTH+1) bits, with no underflow or overflow.

Reset
REQ-029 SHALL, on rst_n low, asynchronously set PC=RESET_PC, occupancy=0, outstanding=0, drop_cnt=0 and state=FETCH.
REQ-030 SHALL drive id_valid=0 and imem_req_valid=0 while reset is asserted.
REQ-031 SHALL, after reset deasserts, drive imem_req_valid=1 in the first cycle with addr=RESET_PC.
REQ-032 SHALL, on reset mid-operation, lose in-flight responses; the memory is reset together with this block.

Configuration
REQ-033 SHALL, with IF_STAGE_PERF_EN defined, add output perf_fetch_cnt 32, cleared on reset, incremented once per id handshake, wrapping at 2^32.
REQ-034 SHALL, without IF_STAGE_PERF_EN, have no such port and no counter logic.

Structure
REQ-035 SHALL place the FSM state typedef (FETCH, FLUSH), the RISC-V instruction field bit positions and the PC increment constant 4 in a shared package, if_pkg.
REQ-036 SHALL use one sub-module, sync_fifo (parameterised width/depth, occupancy output), instantiated twice: as instruction buffer (64-bit {pc,instr}) and as address FIFO.

Verification
REQ-037 Reset, memory always ready, 1-cycle response, id_ready=1 -> id_pc sequence 0x0,0x4,0x8 on consecutive cycles, with id_valid first high 2 cycles after first request.
REQ-038 id_ready=0, BUF_DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0; occupancy=2 and no data lost when id_ready returns high.
REQ-039 2 requests outstanding, redirect_pc=0x100 -> both responses dropped, next id_pc=0x100, state passes through FLUSH for 2 responses.
REQ-040 Redirect with redirect_pc=0x203 in the same cycle as a response and an id handshake -> that response discarded, next imem_req_addr=0x200.
REQ-041 PC=0xFFFF_FFFC fetched -> next imem_req_addr=0x0000_0000.
REQ-042 With IF_STAGE_PERF_EN, 10 accepted instructions with a redirect midway -> perf_fetch_cnt=10; rst_n pulse mid-run -> perf_fetch_cnt=0 and id_valid=0 immediately.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared state type, RISC-V field positions and PC step for the fetch stage.
package if_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  localparam int OPCODE_LSB   = 0;
  localparam int OPCODE_MSB   = 6;
  localparam int FUNCT3_LSB   = 12;
  localparam int FUNCT3_MSB   = 14;
  localparam int FUNCT7_5_BIT = 30;

  localparam logic [31:0] PC_INCR = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with occupancy count and a clear that beats push/pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: credit-based instruction fetch with redirect flush and a small decode buffer.
// Optional perf_fetch_cnt output is built only when IF_STAGE_PERF_EN is defined.
//   state | meaning
//   FETCH | issue requests while credit remains, pair responses with their addresses
//   FLUSH | discard drop_cnt stale responses left over from a redirect, no requests
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic        id_funct7_5
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt
`endif
);

  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int CW1 = CW + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [63:0]   ibuf_head;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_nxt;
  logic [CW-1:0] in_flight;
  logic [CW:0]   used;
  logic          afifo_empty;
  logic          ibuf_empty;
  logic          req_fire;
  logic          rsp_take;
  logic          id_fire;

  // Every outstanding request owns a buffer slot, so the buffer can never overflow.
  assign used           = {1'b0, occupancy} + {1'b0, outstanding};
  assign in_flight      = outstanding + drop_cnt;
  assign imem_req_valid = rst_n && (state == FETCH) && !redirect_valid && (used < CW1'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (state == FETCH) && !redirect_valid && !afifo_empty;
  assign id_valid       = !ibuf_empty;
  assign id_fire        = id_valid && id_ready;

  assign {id_pc, id_instr} = ibuf_head;
  assign id_opcode         = id_instr[OPCODE_MSB:OPCODE_LSB];
  assign id_funct3         = id_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign id_funct7_5       = id_instr[FUNCT7_5_BIT];

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    if (redirect_valid) begin
      drop_nxt  = (imem_rsp_valid && (in_flight != '0)) ? in_flight - CW'(1) : in_flight;
      state_nxt = (drop_nxt != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH) begin
      if (imem_rsp_valid && (drop_cnt != '0)) drop_nxt = drop_cnt - CW'(1);
      if (drop_nxt == '0) state_nxt = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      drop_cnt <= '0;
      pc       <= RESET_PC;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (redirect_valid) pc <= align_pc(redirect_pc);
      else if (req_fire)  pc <= pc + PC_INCR;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (BUF_DEPTH)
  ) u_addr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_take),
    .head_data (rsp_pc),
    .count     (outstanding),
    .empty     (afifo_empty)
  );

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (BUF_DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (rsp_take),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (id_fire),
    .head_data (ibuf_head),
    .count     (occupancy),
    .empty     (ibuf_empty)
  );

`ifdef IF_STAGE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       perf_fetch_cnt <= '0;
    else if (id_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with an in-order memory model and directed plus random traffic.
module tb_if_stage;
  import if_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetch_cnt;
`endif

  if_stage #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_funct3      (id_funct3),
    .id_funct7_5    (id_funct7_5)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        drop;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_acc_addr;
  logic [31:0] last_id_pc;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc, n_id, n_drop, cyc, first_acc, first_id, exp_perf;
  bit          rand_ready, rand_lat, rand_id, hold;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_3C5A;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, then advance the memory model after the rising edge.
  task automatic cycle();
    bit          acc, rsp_seen, any_drop;
    int          live;
    logic [31:0] acc_addr;
    exp_t        e;
    @(negedge clk);
    cyc++;
    any_drop = 0;
    live     = 0;
    foreach (mem_q[i]) begin
      if (mem_q[i].drop) any_drop = 1;
      else               live++;
    end
    check_eq("req_valid", 64'(imem_req_valid),
             64'(!redirect_valid && !any_drop && ((live + exp_q.size()) < DEPTH)));
    check_eq("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    if (acc) begin
      check_eq("req_addr", 64'(imem_req_addr), 64'(exp_pc));
      last_acc_addr = imem_req_addr;
      exp_pc        = exp_pc + 32'd4;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (id_valid && first_id < 0) first_id = cyc;
    if (id_valid && id_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("id_pc", 64'(id_pc), 64'(e.pc));
      check_eq("id_instr", 64'(id_instr), 64'(e.instr));
      check_eq("id_fields", 64'({id_funct7_5, id_funct3, id_opcode}),
               64'({e.instr[30], e.instr[14:12], e.instr[6:0]}));
      last_id_pc = id_pc;
      n_id++;
      exp_perf++;
    end
    if (redirect_valid) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].drop = 1'b1;
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
    rsp_seen = imem_rsp_valid && (mem_q.size() != 0);
    if (rsp_seen) begin
      if (mem_q[0].drop) n_drop++;
      else exp_q.push_back('{pc: mem_q[0].addr, instr: instr_of(mem_q[0].addr)});
    end
    @(posedge clk);
    #1;
    if (rsp_seen) void'(mem_q.pop_front());
    if (acc) mem_q.push_back('{addr: acc_addr, drop: 1'b0});
    imem_rsp_valid = (mem_q.size() != 0) && !hold && (!rand_lat || ($urandom_range(0, 2) == 0));
    imem_rsp_data  = imem_rsp_valid ? instr_of(mem_q[0].addr) : 32'h0;
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rand_id) id_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("rst_id_valid", 64'(id_valid), 64'(0));
    check_eq("rst_req_valid", 64'(imem_req_valid), 64'(0));
`ifdef IF_STAGE_PERF_EN
    check_eq("rst_perf", 64'(perf_fetch_cnt), 64'(0));
`endif
    exp_perf = 0;
    mem_q.delete();
    exp_q.delete();
    exp_pc    = RESET_PC;
    n_acc     = 0;
    n_id      = 0;
    n_drop    = 0;
    first_acc = -1;
    first_id  = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    {rand_ready, rand_lat, rand_id, hold} = '0;
    cyc = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Streaming fetch: first request at the reset PC, decode two cycles later.
    repeat (12) cycle();
    check_eq("first_lat", 64'(first_id - first_acc), 64'(2));
    check_eq("stream_cnt", 64'(n_id >= 3), 64'(1));

    // Decode stalled: only BUF_DEPTH requests may be accepted, nothing lost on release.
    do_reset();
    id_ready = 1'b0;
    repeat (10) cycle();
    check_eq("stall_acc", 64'(n_acc), 64'(DEPTH));
    id_ready = 1'b1;
    repeat (6) cycle();
    check_eq("stall_drain", 64'(n_id >= DEPTH), 64'(1));

    // Two requests in flight when redirected to 0x100: both responses discarded.
    do_reset();
    hold = 1'b1;
    repeat (4) cycle();
    check_eq("hold_acc", 64'(n_acc), 64'(2));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    hold           = 1'b0;
    base           = n_id;
    for (int i = 0; i < 20 && n_id == base; i++) cycle();
    check_eq("flush_drops", 64'(n_drop), 64'(2));
    check_eq("redir_id_pc", 64'(last_id_pc), 64'h100);

    // Redirect coinciding with a response and a decode handshake, unaligned target.
    for (int i = 0; i < 20 && !(imem_rsp_valid && id_valid && id_ready); i++) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    cycle();
    redirect_valid = 1'b0;
    base           = n_acc;
    for (int i = 0; i < 20 && n_acc == base; i++) cycle();
    check_eq("redir_align", 64'(last_acc_addr), 64'h200);

    // PC wraps from the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    base           = n_acc;
    for (int i = 0; i < 20 && n_acc < base + 2; i++) cycle();
    check_eq("pc_wrap", 64'(last_acc_addr), 64'h0);
    repeat (6) cycle();
`ifdef IF_STAGE_PERF_EN
    check_eq("perf_cnt", 64'(perf_fetch_cnt), 64'(exp_perf));
`endif

    // Random ready, latency, decode backpressure and redirects, with a reset mid-run.
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    rand_id    = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
`ifdef IF_STAGE_PERF_EN
        check_eq("perf_mid", 64'(perf_fetch_cnt), 64'(exp_perf));
`endif
        do_reset();
      end
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom;
      cycle();
    end
    redirect_valid = 1'b0;
    rand_ready     = 1'b0;
    rand_lat       = 1'b0;
    rand_id        = 1'b0;
    id_ready       = 1'b1;
    repeat (10) cycle();
`ifdef IF_STAGE_PERF_EN
    check_eq("perf_end", 64'(perf_fetch_cnt), 64'(exp_perf));
`endif
    check_eq("random_flow", 64'(n_id > 20), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
